// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match controller.
//   match_state_t : match-level sequencer states (3-bit encoding)
//   UPD_*         : game-state updater state encodings seen on upd_state
//   WIN_*         : winner output codes
//   winner_code() : threshold-based winner evaluation of two 8-bit scores
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    SERVE     = 3'd2,
    RALLY     = 3'd3,
    PAUSED    = 3'd4,
    GAME_OVER = 3'd5
  } match_state_t;

  localparam logic [1:0] UPD_RESET     = 2'd0;
  localparam logic [1:0] UPD_PLAY_NEXT = 2'd1;
  localparam logic [1:0] UPD_PLAY      = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Each player who has reached the threshold sets its own bit, so a
  // simultaneous finish reports 2'b11 rather than silently picking one.
  function automatic logic [1:0] winner_code(input logic [7:0] p1,
                                             input logic [7:0] p2,
                                             input logic [7:0] win);
    return ((p1 >= win) ? WIN_P1 : WIN_NONE) |
           ((p2 >= win) ? WIN_P2 : WIN_NONE);
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Bus between the match controller and the game-state updater.
//   upd_state      : updater state (UPD_RESET / UPD_PLAY_NEXT / UPD_PLAY)
//   player1_score  : updater score, player 1
//   player2_score  : updater score, player 2
//   upd_rst        : active-high reset to the updater
//   upd_start      : start request to the updater
//   game_vsync     : gated frame strobe, used as the updater clock
// master = controller side, slave = updater side.
interface match_controller_if;

  logic [1:0] upd_state;
  logic [7:0] player1_score;
  logic [7:0] player2_score;
  logic       upd_rst;
  logic       upd_start;
  logic       game_vsync;

  modport master (
    input  upd_state, player1_score, player2_score,
    output upd_rst, upd_start, game_vsync
  );

  modport slave (
    output upd_state, player1_score, player2_score,
    input  upd_rst, upd_start, game_vsync
  );

endinterface

// File: rtl/btn_frame_sampler.sv
// Per-frame button sampler with rising-edge press detection.
//   clk, rst_n   : clock, synchronous active-low reset
//   frame_tick   : one-clk pulse at the start of each frame
//   z1, c1       : player 1 buttons
//   z2, c2       : player 2 buttons
//   start_press  : a Z button went 0->1 between consecutive frame samples
//   pause_press  : a C button went 0->1 between consecutive frame samples
// Both press outputs are only ever high in the frame_tick cycle.
module btn_frame_sampler (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic z1,
  input  logic c1,
  input  logic z2,
  input  logic c2,
  output logic start_press,
  output logic pause_press
);

  logic [3:0] btn_now;
  logic [3:0] sample_q;
  logic [3:0] press;

  assign btn_now = {z1, c1, z2, c2};

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q <= '0;
    end else if (frame_tick) begin
      sample_q <= btn_now;
    end
  end

  // The previous sample only advances on frame_tick, so a press is judged
  // frame-to-frame and bounces between frames are invisible.
  assign press       = btn_now & ~sample_q;
  assign start_press = frame_tick & (press[3] | press[1]);
  assign pause_press = frame_tick & (press[2] | press[0]);

endmodule

// File: rtl/match_controller.sv
// Match-level sequencer for the pong datapath.
//   clk, rst_n  : pixel clock, synchronous active-low reset
//   vsync       : frame sync from the VGA timing generator
//   z1/c1/z2/c2 : Nunchuk buttons (Z = start, C = pause/resume)
//   upd_bus     : updater bus (state and scores in; rst, start, gated vsync out)
//   match_state : current controller state
//   winner      : 01 P1, 10 P2, 11 both, 00 none
//   serve_cnt   : frames remaining in the serve countdown, else 0
// Every decision is taken in the single frame_tick cycle at the vsync rise.
module match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE     = 7,
  parameter int SERVE_FRAMES  = 120,
  parameter int SERVE_TIMEOUT = 4,
  parameter int OVER_FRAMES   = 300,
  parameter int CNT_W         = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               z1,
  input  logic               c1,
  input  logic               z2,
  input  logic               c2,
  match_controller_if.master upd_bus,
  output logic [2:0]         match_state,
  output logic [1:0]         winner,
  output logic [CNT_W-1:0]   serve_cnt
);

  localparam logic [CNT_W-1:0] SERVE_FRAMES_C  = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] SERVE_TIMEOUT_C = CNT_W'(SERVE_TIMEOUT);
  localparam logic [CNT_W-1:0] OVER_FRAMES_C   = CNT_W'(OVER_FRAMES);
  localparam logic [CNT_W-1:0] CD_LAST_C       = CNT_W'(2);
  localparam logic [7:0]       WIN_SCORE_C     = 8'(WIN_SCORE);

  match_state_t     state_q;
  match_state_t     saved_q;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] frame_cnt_inc;
  logic             vsync_q;
  logic             frame_tick;
  logic             start_press;
  logic             pause_press;
  logic             score_reached;

  assign frame_tick    = vsync & ~vsync_q;
  assign match_state   = state_q;
  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign frame_cnt_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;
  assign score_reached = (upd_bus.player1_score >= WIN_SCORE_C) ||
                         (upd_bus.player2_score >= WIN_SCORE_C);

  btn_frame_sampler u_btn (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .z1          (z1),
    .c1          (c1),
    .z2          (z2),
    .c2          (c2),
    .start_press (start_press),
    .pause_press (pause_press)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      saved_q            <= IDLE;
      frame_cnt          <= '0;
      serve_cnt          <= '0;
      winner             <= WIN_NONE;
      vsync_q            <= 1'b0;
      upd_bus.upd_rst    <= 1'b1;
      upd_bus.upd_start  <= 1'b0;
      upd_bus.game_vsync <= 1'b0;
    end else begin
      vsync_q <= vsync;

      // NOTE: this default is overridden below on pause/resume ticks; with
      // non-blocking assignments the last one executed in the block wins, so
      // game_vsync always follows the state being entered this cycle.
      upd_bus.game_vsync <= (state_q == PAUSED) ? 1'b0 : vsync;

      if (frame_tick) begin
        case (state_q)
          IDLE: begin
            upd_bus.upd_rst   <= 1'b1;
            upd_bus.upd_start <= 1'b0;
            if (start_press) begin
              winner          <= WIN_NONE;
              serve_cnt       <= SERVE_FRAMES_C;
              frame_cnt       <= '0;
              upd_bus.upd_rst <= 1'b0;
              state_q         <= COUNTDOWN;
            end
          end

          COUNTDOWN: begin
            if (pause_press) begin
              saved_q            <= COUNTDOWN;
              state_q            <= PAUSED;
              upd_bus.game_vsync <= 1'b0;
            end else if (serve_cnt <= CD_LAST_C) begin
              // This decrement would land on 1: serve instead.
              serve_cnt         <= '0;
              frame_cnt         <= '0;
              upd_bus.upd_start <= 1'b1;
              state_q           <= SERVE;
            end else begin
              serve_cnt <= serve_cnt - 1'b1;
            end
          end

          SERVE: begin
            // upd_start stays high over several updater clocks so the
            // updater sees it whichever game_vsync edge it samples on.
            if (upd_bus.upd_state == UPD_PLAY) begin
              upd_bus.upd_start <= 1'b0;
              state_q           <= RALLY;
            end else begin
              frame_cnt <= frame_cnt_inc;
              if (frame_cnt_inc >= SERVE_TIMEOUT_C) begin
                upd_bus.upd_start <= 1'b0;
                upd_bus.upd_rst   <= 1'b1;
                state_q           <= IDLE;
              end
            end
          end

          RALLY: begin
            upd_bus.upd_start <= 1'b0;
            if (pause_press) begin
              saved_q            <= RALLY;
              state_q            <= PAUSED;
              upd_bus.game_vsync <= 1'b0;
            end else if (upd_bus.upd_state == UPD_PLAY_NEXT) begin
              if (score_reached) begin
                winner    <= winner_code(upd_bus.player1_score,
                                         upd_bus.player2_score, WIN_SCORE_C);
                frame_cnt <= '0;
                state_q   <= GAME_OVER;
              end else begin
                serve_cnt <= SERVE_FRAMES_C;
                state_q   <= COUNTDOWN;
              end
            end
          end

          PAUSED: begin
            // serve_cnt and frame_cnt are simply not touched here.
            if (pause_press) begin
              state_q            <= saved_q;
              upd_bus.game_vsync <= vsync;
            end
          end

          GAME_OVER: begin
            upd_bus.upd_start <= 1'b0;
            frame_cnt         <= frame_cnt_inc;
            if (start_press || (frame_cnt_inc >= OVER_FRAMES_C)) begin
              upd_bus.upd_rst <= 1'b1;
              state_q         <= IDLE;
            end
          end

          default: begin
            upd_bus.upd_rst   <= 1'b1;
            upd_bus.upd_start <= 1'b0;
            serve_cnt         <= '0;
            frame_cnt         <= '0;
            state_q           <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
